// File: rtl/alu_issue_pkg.sv
// ============================================================================
// alu_issue_pkg : shared widths, issue FSM states and FIFO entry type
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_issue_pkg;

  localparam int unsigned C_DATA_W = 8;
  localparam int unsigned C_OP_W   = 3;
  localparam int unsigned C_TAG_W  = 4;
  localparam int unsigned C_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALL = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [C_DATA_W-1:0] data;
    logic [C_OP_W-1:0]   op;
    logic [C_TAG_W-1:0]  tag;
  } alu_res_t;

endpackage

`default_nettype wire

// File: rtl/alu_res_fifo.sv
// ============================================================================
// alu_res_fifo : synchronous result FIFO, wrap-bit pointers, no fall-through
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_res_fifo
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = C_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     i_push,
  input  alu_res_t i_data,
  input  logic     i_pop,
  output logic     o_full,
  output logic     o_empty,
  output alu_res_t o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  alu_res_t    r_mem [DEPTH];
  alu_res_t    r_hold;
  logic        w_rd_en;
  logic        w_wr_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = i_pop & ~o_empty;
  assign w_wr_en = i_push & (~o_full | w_rd_en);

  // When empty the head shows the last popped entry rather than stale storage.
  assign o_head = o_empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_hold   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// alu_issue_stage : registered command/result wrapper around a comb. ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = C_DATA_W,
  parameter int unsigned OP_W   = C_OP_W,
  parameter int unsigned DEPTH  = C_DEPTH,
  parameter int unsigned TAG_W  = C_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_o,
  output logic [OP_W-1:0]   res_op_o,
  output logic [TAG_W-1:0]  res_tag_o,
  output logic [15:0]       cmd_cnt_o
);

  issue_state_e      r_state;
  issue_state_e      w_state_nxt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]  r_tag_cnt;
  logic [15:0]       r_cmd_cnt;

  logic              w_issue_valid;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  alu_res_t          w_push_data;
  alu_res_t          w_head;

  assign w_issue_valid = (r_state != IDLE);
  assign res_valid_o   = ~w_empty;
  assign w_pop         = res_valid_o & res_ready_i;
  assign w_push        = w_issue_valid & (~w_full | w_pop);
  assign cmd_ready_o   = ~reset & (~w_issue_valid | w_push);
  assign w_accept      = cmd_valid_i & cmd_ready_o;

  assign alu_a_o  = r_a;
  assign alu_b_o  = r_b;
  assign alu_op_o = r_op;
  assign cmd_cnt_o = r_cmd_cnt;

  always_comb begin
    w_push_data      = '0;
    w_push_data.data = alu_res_i;
    w_push_data.op   = r_op;
    w_push_data.tag  = r_tag;
  end

  assign res_o     = w_head.data;
  assign res_op_o  = w_head.op;
  assign res_tag_o = w_head.tag;

  // A push without a replacement command empties the issue register.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = BUSY;
      end
      BUSY, STALL: begin
        if (w_push) w_state_nxt = w_accept ? BUSY : IDLE;
        else        w_state_nxt = STALL;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_tag     <= '0;
      r_tag_cnt <= '0;
      r_cmd_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a       <= cmd_a_i;
        r_b       <= cmd_b_i;
        r_op      <= cmd_op_i;
        r_tag     <= r_tag_cnt;
        r_tag_cnt <= r_tag_cnt + 1'b1;
        r_cmd_cnt <= r_cmd_cnt + 16'd1;
      end
    end
  end

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// tb_alu_issue_stage : directed stimulus with queue scoreboard, XOR stub ALU
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] cmd_a_i = '0;
  logic [7:0] cmd_b_i = '0;
  logic [2:0] cmd_op_i = '0;
  logic [7:0] alu_a_o;
  logic [7:0] alu_b_o;
  logic [2:0] alu_op_o;
  logic [7:0] alu_res_i;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;
  logic [7:0] res_o;
  logic [2:0] res_op_o;
  logic [3:0] res_tag_o;
  logic [15:0] cmd_cnt_o;

  always #5 clk = ~clk;

  assign alu_res_i = alu_a_o ^ alu_b_o;

  alu_issue_stage dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .cmd_op_i    (cmd_op_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_o       (res_o),
    .res_op_o    (res_op_o),
    .res_tag_o   (res_tag_o),
    .cmd_cnt_o   (cmd_cnt_o)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] op;
    logic [3:0] tag;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] tag_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!reset && res_valid_o && res_ready_i) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got tag %0d data 0x%0h expected none", res_tag_o, res_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", 32'(res_o), 32'(e.data));
        chk("res_op", 32'(res_op_o), 32'(e.op));
        chk("res_tag", 32'(res_tag_o), 32'(e.tag));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input bit expect_now);
    int waited;
    exp_t e;
    waited = 0;
    cmd_valid_i = 1'b1;
    cmd_a_i = a;
    cmd_b_i = b;
    cmd_op_i = op;
    @(negedge clk);
    while (!cmd_ready_o && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (expect_now) chk("cmd_ready_immediate", 32'(waited), 32'd0);
    if (!cmd_ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got cmd_ready_o=0 expected 1 within 20 cycles");
    end else begin
      e.data = a ^ b;
      e.op = op;
      e.tag = tag_m;
      q.push_back(e);
      tag_m = tag_m + 4'd1;
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("fifo_empty_after_drain", 32'(res_valid_o), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    tag_m = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_alu_a", 32'(alu_a_o), 32'd0);
    chk("rst_alu_b", 32'(alu_b_o), 32'd0);
    chk("rst_alu_op", 32'(alu_op_o), 32'd0);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res", 32'(res_o), 32'd0);
    chk("rst_res_op", 32'(res_op_o), 32'd0);
    chk("rst_res_tag", 32'(res_tag_o), 32'd0);
    chk("rst_cmd_cnt", 32'(cmd_cnt_o), 32'd0);
    reset = 1'b0;

    // Single command and two-cycle latency.
    res_ready_i = 1'b1;
    send(8'h0F, 8'hF0, 3'd2, 1'b1);
    @(negedge clk);
    chk("no_fallthrough", 32'(res_valid_o), 32'd0);
    @(negedge clk);
    chk("latency_valid", 32'(res_valid_o), 32'd1);
    chk("single_res", 32'(res_o), 32'h0000_00FF);
    chk("single_cnt", 32'(cmd_cnt_o), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Back-to-back at full throughput.
    for (int i = 0; i < 6; i++) begin
      send(8'(i), 8'h01, 3'(i), 1'b1);
    end
    drain();
    chk("b2b_cnt", 32'(cmd_cnt_o), 32'd7);

    // Backpressure: two in the FIFO, one stalled in the issue register.
    res_ready_i = 1'b0;
    send(8'h10, 8'h20, 3'd1, 1'b1);
    send(8'h11, 8'h22, 3'd3, 1'b1);
    send(8'h12, 8'h24, 3'd4, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_a_i = 8'h13;
    cmd_b_i = 8'h26;
    cmd_op_i = 3'd6;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(cmd_ready_o), 32'd0);
      chk("bp_head_valid", 32'(res_valid_o), 32'd1);
      chk("bp_head_data", 32'(res_o), 32'h0000_0030);
      chk("bp_head_tag", 32'(res_tag_o), 32'd7);
    end
    @(posedge clk);
    #1;
    res_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_ready_on_pop", 32'(cmd_ready_o), 32'd1);
    if (cmd_ready_o) begin
      e.data = 8'h13 ^ 8'h26;
      e.op = 3'd6;
      e.tag = tag_m;
      q.push_back(e);
      tag_m = tag_m + 4'd1;
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    chk("full_pop_push_stays_full", 32'(dut.w_full), 32'd1);
    drain();
    chk("bp_cnt", 32'(cmd_cnt_o), 32'd11);

    // Tag wrap over 17 commands.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'(8'h40 + i), 8'(i * 3), 3'(i), 1'b1);
    end
    drain();
    chk("wrap_cnt", 32'(cmd_cnt_o), 32'd17);
    chk("wrap_last_tag", 32'(res_tag_o), 32'd0);

    // Reset with 2 results queued plus 1 in issue.
    res_ready_i = 1'b0;
    send(8'hA1, 8'h01, 3'd1, 1'b1);
    send(8'hA2, 8'h02, 3'd2, 1'b1);
    send(8'hA3, 8'h03, 3'd3, 1'b1);
    reset = 1'b1;
    q.delete();
    tag_m = '0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("mid_rst_cnt", 32'(cmd_cnt_o), 32'd0);
    chk("mid_rst_ready2", 32'(cmd_ready_o), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    res_ready_i = 1'b1;
    send(8'h33, 8'h0C, 3'd5, 1'b1);
    drain();
    chk("post_rst_tag", 32'(res_tag_o), 32'd0);
    chk("post_rst_cnt", 32'(cmd_cnt_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
